// File: rtl/match_ctrl_pkg.sv
// rtl/match_ctrl_pkg.sv - shared match state encoding and default match timing
package match_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } match_state_e;

   localparam int DEF_SCORE_W      = 4;
   localparam int DEF_WIN_SCORE    = 9;
   localparam int DEF_SERVE_FRAMES = 60;
   localparam int DEF_POINT_FRAMES = 30;
   localparam int DEF_FRAME_CNT_W  = 8;

endpackage

// File: rtl/match_ctrl_frame_timer.sv
// rtl/match_ctrl_frame_timer.sv - frame tick counter with same-cycle terminal pulse
module match_ctrl_frame_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_load,
   input  logic             i_tick,
   input  logic [CNT_W-1:0] i_term,
   output logic             o_done
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   // done is combinational so the FSM can leave on the very tick that reaches the count
   assign w_last = (r_cnt == i_term - CNT_W'(1));
   assign o_done = i_tick & w_last;

   always_ff @(posedge clk_i) begin
      if (rst_i || i_load) begin
         r_cnt <= '0;
      end else if (i_tick) begin
         r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - match sequencer: serve countdown, play, point pause, game over
module match_ctrl
   import match_ctrl_pkg::*;
#(
   parameter int SCORE_W      = DEF_SCORE_W,
   parameter int WIN_SCORE    = DEF_WIN_SCORE,
   parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
   parameter int POINT_FRAMES = DEF_POINT_FRAMES,
   parameter int FRAME_CNT_W  = DEF_FRAME_CNT_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               new_frame_i,
   input  logic               start_i,
   input  logic               miss_l_i,
   input  logic               miss_r_i,
   output logic               play_en_o,
   output logic               ball_rst_o,
   output logic               serve_dir_o,
   output logic [SCORE_W-1:0] score_l_o,
   output logic [SCORE_W-1:0] score_r_o,
   output logic [2:0]         state_o,
   output logic               game_over_o,
   output logic               winner_o
);

   localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

   match_state_e        r_state;
   logic [SCORE_W-1:0]  r_score_l;
   logic [SCORE_W-1:0]  r_score_r;
   logic                r_play_en;
   logic                r_ball_rst;
   logic                r_serve_dir;
   logic                r_game_over;
   logic                r_winner;
   logic                r_start_q;

   logic                   w_restart;
   logic                   w_tick;
   logic                   w_done;
   logic [FRAME_CNT_W-1:0] w_term;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s >= WIN_S) ? s : s + SCORE_W'(1);
   endfunction

   // OVER needs an edge so a key still held from the last match cannot restart it
   assign w_restart = ((r_state == ST_IDLE) && start_i) ||
                      ((r_state == ST_OVER) && start_i && !r_start_q);
   assign w_tick    = new_frame_i && ((r_state == ST_SERVE) || (r_state == ST_POINT));
   assign w_term    = (r_state == ST_SERVE) ? FRAME_CNT_W'(SERVE_FRAMES)
                                            : FRAME_CNT_W'(POINT_FRAMES);

   match_ctrl_frame_timer #(
      .CNT_W (FRAME_CNT_W)
   ) u_timer (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .i_load (w_restart),
      .i_tick (w_tick),
      .i_term (w_term),
      .o_done (w_done)
   );

   always_ff @(posedge clk_i) begin
      r_start_q  <= start_i;
      r_ball_rst <= 1'b0;
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_score_l   <= '0;
         r_score_r   <= '0;
         r_play_en   <= 1'b0;
         r_serve_dir <= 1'b0;
         r_game_over <= 1'b0;
         r_winner    <= 1'b0;
         r_start_q   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_OVER: begin
               r_play_en <= 1'b0;
               if (w_restart) begin
                  r_state     <= ST_SERVE;
                  r_score_l   <= '0;
                  r_score_r   <= '0;
                  r_ball_rst  <= 1'b1;
                  r_game_over <= 1'b0;
                  r_winner    <= 1'b0;
               end
            end
            ST_SERVE: begin
               r_play_en <= 1'b0;
               if (w_done) r_state <= ST_PLAY;
            end
            ST_PLAY: begin
               // play_en drops together with the state change on a miss
               if (miss_l_i && miss_r_i) begin
                  r_serve_dir <= ~r_serve_dir;
                  r_play_en   <= 1'b0;
                  r_state     <= ST_POINT;
               end else if (miss_l_i) begin
                  r_score_r   <= sat_inc(r_score_r);
                  r_serve_dir <= 1'b0;
                  r_play_en   <= 1'b0;
                  r_state     <= ST_POINT;
               end else if (miss_r_i) begin
                  r_score_l   <= sat_inc(r_score_l);
                  r_serve_dir <= 1'b1;
                  r_play_en   <= 1'b0;
                  r_state     <= ST_POINT;
               end else begin
                  r_play_en   <= 1'b1;
               end
            end
            ST_POINT: begin
               r_play_en <= 1'b0;
               if (w_done) begin
                  if ((r_score_l == WIN_S) || (r_score_r == WIN_S)) begin
                     r_state     <= ST_OVER;
                     r_game_over <= 1'b1;
                     r_winner    <= (r_score_r == WIN_S);
                  end else begin
                     r_state    <= ST_SERVE;
                     r_ball_rst <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign play_en_o   = r_play_en;
   assign ball_rst_o  = r_ball_rst;
   assign serve_dir_o = r_serve_dir;
   assign score_l_o   = r_score_l;
   assign score_r_o   = r_score_r;
   assign state_o     = r_state;
   assign game_over_o = r_game_over;
   assign winner_o    = r_winner;

endmodule

// File: tb/tb_match_ctrl.sv
// tb/tb_match_ctrl.sv - directed self-checking bench for match_ctrl
module tb_match_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       new_frame_i;
   logic       start_i;
   logic       miss_l_i;
   logic       miss_r_i;
   logic       play_en_o;
   logic       ball_rst_o;
   logic       serve_dir_o;
   logic [3:0] score_l_o;
   logic [3:0] score_r_o;
   logic [2:0] state_o;
   logic       game_over_o;
   logic       winner_o;

   int n_checks = 0;
   int n_fail   = 0;

   match_ctrl dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .new_frame_i (new_frame_i),
      .start_i     (start_i),
      .miss_l_i    (miss_l_i),
      .miss_r_i    (miss_r_i),
      .play_en_o   (play_en_o),
      .ball_rst_o  (ball_rst_o),
      .serve_dir_o (serve_dir_o),
      .score_l_o   (score_l_o),
      .score_r_o   (score_r_o),
      .state_o     (state_o),
      .game_over_o (game_over_o),
      .winner_o    (winner_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         new_frame_i = 1'b1;
         step();
         new_frame_i = 1'b0;
         step();
      end
   endtask

   // From SERVE: countdown, one PLAY cycle, a miss, then the full point pause
   task automatic play_point(input logic ml, input logic mr, input logic [3:0] el,
                             input logic [3:0] er, input logic [2:0] end_state);
      frames(60);
      check_eq("pp_state_play", state_o, 3'd2);
      step();
      check_eq("pp_play_en", play_en_o, 1'b1);
      miss_l_i = ml;
      miss_r_i = mr;
      step();
      miss_l_i = 1'b0;
      miss_r_i = 1'b0;
      check_eq("pp_state_point", state_o, 3'd3);
      check_eq("pp_score_l", score_l_o, el);
      check_eq("pp_score_r", score_r_o, er);
      frames(30);
      check_eq("pp_state_end", state_o, end_state);
   endtask

   initial begin
      rst_i = 1'b1; new_frame_i = 1'b0; start_i = 1'b0; miss_l_i = 1'b0; miss_r_i = 1'b0;
      step(); step();
      rst_i = 1'b0;
      check_eq("rst_state", state_o, 3'd0);
      check_eq("rst_score_l", score_l_o, 4'd0);
      check_eq("rst_score_r", score_r_o, 4'd0);
      check_eq("rst_play_en", play_en_o, 1'b0);
      check_eq("rst_ball_rst", ball_rst_o, 1'b0);
      check_eq("rst_serve_dir", serve_dir_o, 1'b0);
      check_eq("rst_game_over", game_over_o, 1'b0);
      check_eq("rst_winner", winner_o, 1'b0);

      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check_eq("start_state", state_o, 3'd1);
      check_eq("start_ball_rst", ball_rst_o, 1'b1);
      step();
      check_eq("start_ball_rst_w", ball_rst_o, 1'b0);

      frames(59);
      check_eq("serve_59", state_o, 3'd1);
      new_frame_i = 1'b1;
      step();
      new_frame_i = 1'b0;
      check_eq("serve_60_state", state_o, 3'd2);
      check_eq("play_entry_en", play_en_o, 1'b0);
      step();
      check_eq("play_en_late", play_en_o, 1'b1);

      miss_r_i = 1'b1;
      step();
      miss_r_i = 1'b0;
      check_eq("mr_state", state_o, 3'd3);
      check_eq("mr_score_l", score_l_o, 4'd1);
      check_eq("mr_score_r", score_r_o, 4'd0);
      check_eq("mr_serve_dir", serve_dir_o, 1'b1);
      check_eq("mr_play_en", play_en_o, 1'b0);
      frames(29);
      check_eq("point_29", state_o, 3'd3);
      new_frame_i = 1'b1;
      step();
      new_frame_i = 1'b0;
      check_eq("point_30_state", state_o, 3'd1);
      check_eq("point_30_ball_rst", ball_rst_o, 1'b1);
      step();
      check_eq("point_ball_rst_w", ball_rst_o, 1'b0);

      // both misses with a coincident frame: no score, dir toggles, frame not counted
      frames(60);
      step();
      miss_l_i = 1'b1; miss_r_i = 1'b1; new_frame_i = 1'b1;
      step();
      miss_l_i = 1'b0; miss_r_i = 1'b0; new_frame_i = 1'b0;
      check_eq("both_state", state_o, 3'd3);
      check_eq("both_score_l", score_l_o, 4'd1);
      check_eq("both_score_r", score_r_o, 4'd0);
      check_eq("both_serve_dir", serve_dir_o, 1'b0);
      frames(29);
      check_eq("both_frame_ignored", state_o, 3'd3);
      frames(1);
      check_eq("both_back_serve", state_o, 3'd1);

      play_point(1'b1, 1'b0, 4'd1, 4'd1, 3'd1);
      check_eq("ml_serve_dir", serve_dir_o, 1'b0);

      for (int p = 2; p <= 8; p++) begin
         play_point(1'b0, 1'b1, 4'(p), 4'd1, 3'd1);
      end
      start_i = 1'b1;
      play_point(1'b0, 1'b1, 4'd9, 4'd1, 3'd4);
      check_eq("over_game_over", game_over_o, 1'b1);
      check_eq("over_winner", winner_o, 1'b0);
      check_eq("over_score_l", score_l_o, 4'd9);
      check_eq("over_play_en", play_en_o, 1'b0);

      miss_r_i = 1'b1;
      step();
      miss_r_i = 1'b0;
      step(); step();
      check_eq("over_held_start", state_o, 3'd4);
      check_eq("over_sat_l", score_l_o, 4'd9);

      start_i = 1'b0;
      step();
      check_eq("over_start_low", state_o, 3'd4);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check_eq("restart_state", state_o, 3'd1);
      check_eq("restart_score_l", score_l_o, 4'd0);
      check_eq("restart_score_r", score_r_o, 4'd0);
      check_eq("restart_game_over", game_over_o, 1'b0);
      check_eq("restart_ball_rst", ball_rst_o, 1'b1);

      play_point(1'b0, 1'b1, 4'd1, 4'd0, 3'd1);
      play_point(1'b1, 1'b0, 4'd1, 4'd1, 3'd1);
      play_point(1'b0, 1'b1, 4'd2, 4'd1, 3'd1);
      play_point(1'b1, 1'b0, 4'd2, 4'd2, 3'd1);
      play_point(1'b0, 1'b1, 4'd3, 4'd2, 3'd1);
      frames(60);
      step();
      check_eq("pre_rst_play_en", play_en_o, 1'b1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check_eq("midrst_state", state_o, 3'd0);
      check_eq("midrst_score_l", score_l_o, 4'd0);
      check_eq("midrst_score_r", score_r_o, 4'd0);
      check_eq("midrst_play_en", play_en_o, 1'b0);
      check_eq("midrst_serve_dir", serve_dir_o, 1'b0);

      miss_l_i = 1'b1; miss_r_i = 1'b1;
      step();
      miss_l_i = 1'b0; miss_r_i = 1'b0;
      check_eq("idle_miss_state", state_o, 3'd0);
      check_eq("idle_miss_score_r", score_r_o, 4'd0);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      miss_l_i = 1'b1;
      step();
      miss_l_i = 1'b0;
      check_eq("serve_miss_state", state_o, 3'd1);
      check_eq("serve_miss_score_r", score_r_o, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
